// File: rtl/gcd_dispatch.sv
// Queues operand pairs and dispatches them one at a time to an external GCD core.
// Zero operands are resolved locally; a silent core becomes an error result after TIMEOUT cycles.
module gcd_dispatch #(
    parameter int W       = 7,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    output logic                   in_ready,
    output logic                   start,
    output logic [W-1:0]           x,
    output logic [W-1:0]           y,
    input  logic                   core_done,
    input  logic [W-1:0]           core_result,
    output logic                   res_valid,
    output logic [W-1:0]           res_data,
    output logic                   res_err,
    input  logic                   res_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2*W-1:0] mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;
    logic           head_zero;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [7:0]     tmo_cnt;
    logic           tmo_hit;

    // Both ports transfer on the cycle where valid and ready are high together;
    // valid never waits on ready, and the payload must be held until the transfer.
    assign in_ready  = rst & (count < FULL);
    assign push      = in_valid & in_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign {head_a, head_b} = mem[rd_ptr];
    assign head_zero = (head_a == '0) || (head_b == '0);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign x         = op_a;
    assign y         = op_b;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = head_zero ? OUT : ISSUE;
                end
            end
            ISSUE: begin
                start     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (core_done || tmo_hit) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // core_done has priority over the timeout when both land on the last WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a     <= '0;
            op_b     <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        op_a <= head_a;
                        op_b <= head_b;
                        if (head_zero) begin
                            res_data <= head_a | head_b;
                            res_err  <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    if (core_done) begin
                        res_data <= core_result;
                        res_err  <= 1'b0;
                    end else if (tmo_hit) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_dispatch.sv
// Bench for gcd_dispatch: a behavioural GCD core stand-in plus a queue of expected
// results computed with Euclid's algorithm, exercised by one task per scenario.
module tb_gcd_dispatch;

    localparam int W       = 7;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         core_done = 1'b0;
    logic [W-1:0] core_result = '0;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_err;
    logic         res_ready = 1'b0;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    int           start_cnt = 0;
    logic [W-1:0] last_x = '0;
    logic [W-1:0] last_y = '0;
    bit           core_stall = 1'b0;
    int           core_lat = 0;
    int           core_timer = -1;
    logic [W-1:0] core_val = '0;
    bit           stray_done = 1'b0;

    always #5 clk = ~clk;

    gcd_dispatch #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .start(start), .x(x), .y(y),
        .core_done(core_done), .core_result(core_result),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .res_ready(res_ready), .count(count)
    );

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned p = a;
        int unsigned q = b;
        int unsigned t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return W'(p);
    endfunction

    // GCD core stand-in: answers each start after a latency unless stalled.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (!rst) begin
            core_timer = -1;
        end else begin
            if (stray_done) begin
                core_done   = 1'b1;
                core_result = 7'd55;
                stray_done  = 1'b0;
            end else if (core_timer > 0 && !core_stall) begin
                core_timer--;
                if (core_timer == 0) begin
                    core_done   = 1'b1;
                    core_result = core_val;
                    core_timer  = -1;
                end
            end
            if (start) begin
                start_cnt++;
                last_x     = x;
                last_y     = y;
                core_val   = ref_gcd(x, y);
                core_timer = (core_lat > 0) ? core_lat : int'($urandom_range(1, 8));
            end
        end
    end

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        int n = 0;
        while (!in_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (ok) begin
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            @(negedge clk);
            in_valid = 1'b0;
            exp_q.push_back(ref_gcd(a, b));
        end
    endtask

    task automatic pop_res(input int hold, output logic [W-1:0] d, output logic e, output bit ok);
        int n = 0;
        while (!res_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = res_valid;
        d  = res_data;
        e  = res_err;
        if (ok) begin
            repeat (hold) @(negedge clk);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, start, x, y, res_valid, res_data, res_err} !== 25'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {in_ready, start, x, y, res_valid, res_data, res_err});
        end
        checks++;
        if (count !== 0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        bit ok, got;
        logic [W-1:0] d, exp;
        logic e;
        int s0 = start_cnt;
        core_lat = 5;
        push(7'd60, 7'd40, ok);
        pop_res(0, d, e, got);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        checks++;
        if (!ok || !got || d !== 7'd20 || e !== 1'b0 || exp !== 7'd20) begin
            errors++;
            $display("FAIL basic_result got %0d err %0b want 20 err 0", d, e);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL basic_starts got %0d want 1", start_cnt - s0);
        end
        checks++;
        if (last_x !== 7'd60 || last_y !== 7'd40) begin
            errors++;
            $display("FAIL basic_xy got %0d,%0d want 60,40", last_x, last_y);
        end
    endtask

    task automatic test_zero_operands();
        bit ok1, ok2;
        logic [W-1:0] e9, e0;
        int s0 = start_cnt;
        push(7'd0, 7'd9, ok1);
        e9 = exp_q.pop_front();
        @(negedge clk);
        checks++;
        if (!ok1 || {res_valid, res_data, res_err} !== {1'b1, e9, 1'b0}) begin
            errors++;
            $display("FAIL zero_first got v%0b d%0d e%0b want v1 d%0d e0", res_valid, res_data, res_err, e9);
        end
        push(7'd0, 7'd0, ok2);
        e0 = exp_q.pop_front();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_gap got v%0b want v0", res_valid);
        end
        @(negedge clk);
        checks++;
        if (!ok2 || {res_valid, res_data, res_err} !== {1'b1, e0, 1'b0}) begin
            errors++;
            $display("FAIL zero_second got v%0b d%0d e%0b want v1 d%0d e0", res_valid, res_data, res_err, e0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (start_cnt !== s0) begin
            errors++;
            $display("FAIL zero_no_start got %0d starts want 0", start_cnt - s0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, all_ok, leaked, held_ok, got;
        int n;
        logic [W-1:0] d, exp, a5, b5;
        logic e;
        core_lat   = 3;
        core_stall = 1'b1;
        all_ok     = 1'b1;
        push(7'd30, 7'd45, ok);
        all_ok &= ok;
        n = 0;
        while (!start && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            push(W'($urandom_range(1, 127)), W'($urandom_range(1, 127)), ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok || count !== 4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full got count %0d ready %0b ok %0b want count 4 ready 0 ok 1", count, in_ready, all_ok);
        end
        a5 = W'($urandom_range(1, 127));
        b5 = W'($urandom_range(1, 127));
        in_valid = 1'b1;
        in_a = a5;
        in_b = b5;
        leaked = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL b2b_held got ready 1 while full want 0");
        end
        core_stall = 1'b0;
        fork
            begin
                n = 0;
                while (!in_ready && n < 600) begin
                    @(negedge clk);
                    n++;
                end
                held_ok = in_ready;
                @(negedge clk);
                in_valid = 1'b0;
                if (held_ok) exp_q.push_back(ref_gcd(a5, b5));
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    pop_res(int'($urandom_range(0, 2)), d, e, got);
                    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                    checks++;
                    if (!got || d !== exp || e !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_result[%0d] got %0d err %0b want %0d err 0", i, d, e, exp);
                    end
                end
            end
        join
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL b2b_fifth_accept got not accepted want accepted");
        end
    endtask

    task automatic test_hold();
        bit ok, stable, got;
        logic [W-1:0] exp13, d, exp, a, b;
        logic e;
        int s0 = start_cnt;
        core_lat = 0;
        push(7'd0, 7'd13, ok);
        exp13 = exp_q.pop_front();
        @(negedge clk);
        stable = ok;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                a = W'($urandom_range(1, 127));
                b = W'($urandom_range(1, 127));
                in_valid = 1'b1;
                in_a = a;
                in_b = b;
                exp_q.push_back(ref_gcd(a, b));
            end else begin
                in_valid = 1'b0;
            end
            if ({res_valid, res_data, res_err} !== {1'b1, exp13, 1'b0}) stable = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!stable || {res_valid, res_data, res_err} !== {1'b1, exp13, 1'b0}) begin
            errors++;
            $display("FAIL hold_stable got v%0b d%0d e%0b want v1 d%0d e0", res_valid, res_data, res_err, exp13);
        end
        checks++;
        if (count !== 3 || start_cnt !== s0) begin
            errors++;
            $display("FAIL hold_queue got count %0d starts %0d want count 3 starts 0", count, start_cnt - s0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pop_res(0, d, e, got);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            checks++;
            if (!got || d !== exp || e !== 1'b0) begin
                errors++;
                $display("FAIL hold_drain[%0d] got %0d err %0b want %0d err 0", i, d, e, exp);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        core_stall = 1'b1;
        push(7'd12, 7'd8, ok);
        n = 0;
        while (!start && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!res_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ok || n !== TIMEOUT + 1 || res_valid !== 1'b1 || res_data !== 7'd0 || res_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout got cycles %0d v%0b d%0d e%0b want cycles %0d v1 d0 e1",
                     n, res_valid, res_data, res_err, TIMEOUT + 1);
        end
        core_timer = -1;
        exp_q.delete();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        @(negedge clk);
        core_stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok, all_ok, seen;
        int n;
        int s0;
        core_stall = 1'b1;
        push(7'd21, 7'd14, ok);
        all_ok = ok;
        n = 0;
        while (!start && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        push(7'd9, 7'd6, ok);
        all_ok &= ok;
        push(7'd10, 7'd4, ok);
        all_ok &= ok;
        checks++;
        if (!all_ok || count !== 2) begin
            errors++;
            $display("FAIL rstmid_queued got count %0d want 2", count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, start, x, y, res_valid, res_data, res_err} !== 25'h0 || count !== 0) begin
            errors++;
            $display("FAIL rstmid_outputs got %h count %0d want 0 count 0",
                     {in_ready, start, x, y, res_valid, res_data, res_err}, count);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        core_stall = 1'b0;
        s0 = start_cnt;
        @(negedge clk);
        stray_done = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid || start) seen = 1'b1;
        end
        checks++;
        if (seen || start_cnt !== s0 || count !== 0) begin
            errors++;
            $display("FAIL rstmid_stray got activity %0b starts %0d count %0d want 0 0 0", seen, start_cnt - s0, count);
        end
    endtask

    task automatic test_random();
        int push_fail = 0;
        core_lat = 0;
        fork
            begin
                bit ok;
                logic [W-1:0] a, b;
                for (int i = 0; i < 24; i++) begin
                    a = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 127));
                    b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 127));
                    push(a, b, ok);
                    if (!ok) push_fail++;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                bit got;
                logic [W-1:0] d, exp;
                logic e;
                for (int i = 0; i < 24; i++) begin
                    pop_res(int'($urandom_range(0, 3)), d, e, got);
                    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                    checks++;
                    if (!got || d !== exp || e !== 1'b0) begin
                        errors++;
                        $display("FAIL random[%0d] got %0d err %0b want %0d err 0", i, d, e, exp);
                    end
                end
            end
        join
        checks++;
        if (push_fail != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_flow got push_fail %0d leftover %0d want 0 0", push_fail, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_operands();
        test_back_to_back();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gcd_dispatch.md
GCD_DISPATCH -- requirements
Module: gcd_dispatch

Interface
REQ-001 Parameter: W, 7, operand/result width in bits.
REQ-002 Parameter: DEPTH, 4, operand-pair queue depth in entries (power of two).
REQ-003 Parameter: TIMEOUT, 255, maximum cycles to wait for core_done (8-bit counter).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-006 in_valid  input  1  upstream offers an operand pair.
REQ-007 in_a  input  W  operand A.
REQ-008 in_b  input  W  operand B.
REQ-009 in_ready  output  1  queue can accept a pair this cycle.
REQ-010 start  output  1  one-cycle pulse to the GCD core.
REQ-011 x  output  W  operand A to core.
REQ-012 y  output  W  operand B to core.
REQ-013 core_done  input  1  core result valid (one-cycle pulse).
REQ-014 core_result  input  W  core GCD value.
REQ-015 res_valid  output  1  result available downstream.
REQ-016 res_data  output  W  GCD result.
REQ-017 res_err  output  1  result produced by timeout, not by core.
REQ-018 res_ready  input  1  downstream accepts result.
REQ-019 count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-020 in_ready SHALL equal (count < DEPTH) and be 0 while rst is low; push occurs on in_valid & in_ready.
REQ-021 Queue SHALL be strict FIFO; pointers SHALL wrap modulo DEPTH; push and pop in the same cycle SHALL leave count unchanged.
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT, OUT.
REQ-023 IDLE with count > 0 SHALL pop the head pair into internal op_a/op_b; a pair pushed at edge k SHALL be popped no earlier than edge k+1.
REQ-024 On pop, if op_a == 0 or op_b == 0, next state SHALL be OUT with res_data = op_a | op_b, res_err = 0, and no start pulse (gcd(0,0) = 0).
REQ-025 On pop with both operands nonzero, next state SHALL be ISSUE.
REQ-026 ISSUE SHALL assert start for exactly one cycle, then go to WAIT; x/y SHALL equal op_a/op_b from ISSUE through the end of WAIT.
REQ-027 WAIT SHALL capture core_result into res_data on core_done, with res_err = 0, then go to OUT.
REQ-028 WAIT SHALL count cycles from entry; if TIMEOUT cycles elapse without core_done, it SHALL set res_data = 0, res_err = 1 and go to OUT.
REQ-029 core_done outside WAIT SHALL be ignored.
REQ-030 OUT SHALL assert res_valid and hold res_data/res_err stable until res_valid & res_ready, then return to IDLE.
REQ-031 No pop and no start SHALL occur while in WAIT or OUT; the queue SHALL continue accepting pushes in all states.
REQ-032 Result order SHALL match input order.

Reset
REQ-033 While rst is low: state = IDLE, queue empty, count = 0, start = 0, x = y = 0, res_valid = 0, res_data = 0, res_err = 0, timeout counter = 0.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight pair and all queued pairs; no start pulse or res_valid SHALL follow from pre-reset data.

Verification
REQ-035 Push (60,40); core model returns 20 after 5 cycles -> exactly one start with x=60, y=40; res_valid with res_data=20, res_err=0.
REQ-036 Push (0,9), then (0,0) -> no start; res_data=9, then res_data=0, each res_valid the cycle after its pop.
REQ-037 Core stalled; push 5 pairs back-to-back -> in_ready falls after the 4th accept, 5th held until a pop; results emerge in push order.
REQ-038 Hold res_ready=0 for 10 cycles in OUT -> res_valid/res_data stable; no start; queue still fills.
REQ-039 Push (12,8) and never assert core_done -> after 255 WAIT cycles res_valid=1, res_err=1, res_data=0.
REQ-040 Assert rst low during WAIT with 2 pairs queued -> count=0, all outputs 0; a stray core_done after release is ignored.
